// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier error sweeper.
package approx_mult_pkg;

   localparam int SCALE_W = 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DIV,
      ST_ACC,
      ST_DONE
   } sweep_state_e;

   // Divider length equals its dividend width: one quotient bit per cycle.
   function automatic int div_cycles(int w);
      return 2 * w + SCALE_W;
   endfunction

   function automatic logic [63:0] exact_product(logic [31:0] a, logic [31:0] b);
      return 64'(a) * 64'(b);
   endfunction

endpackage

// File: rtl/seq_div_restoring.sv
// Unsigned restoring divider; first quotient bit is produced on the start edge,
// done pulses in the NW-th cycle after start, with the quotient already valid.
module seq_div_restoring #(
   parameter int NW = 30,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          flush_i,
   input  logic [NW-1:0] dividend_i,
   input  logic [DW-1:0] divisor_i,
   output logic          done_o,
   output logic [NW-1:0] quotient_o
);
   localparam int CNT_W = $clog2(NW + 1);

   logic [DW-1:0]    rem_q, rem_d, dvs_q, dvs_d, src_rem, src_dvs;
   logic [NW-1:0]    quo_q, quo_d, src_quo;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [DW:0]      trial;
   logic             fits;

   always_comb begin
      src_rem = start_i ? '0 : rem_q;
      src_quo = start_i ? dividend_i : quo_q;
      src_dvs = start_i ? divisor_i : dvs_q;
      trial   = {src_rem, src_quo[NW-1]};
      fits    = (trial >= {1'b0, src_dvs});
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (flush_i) begin
         cnt_d = '0;
      end else if (start_i || (cnt_q != '0)) begin
         rem_d  = fits ? DW'(trial - {1'b0, src_dvs}) : trial[DW-1:0];
         quo_d  = {src_quo[NW-2:0], fits};
         dvs_d  = src_dvs;
         cnt_d  = start_i ? CNT_W'(NW - 1) : cnt_q - CNT_W'(1);
         done_d = (cnt_d == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/approx_mult_err_sweeper.sv
// Exhaustive accuracy sweep of an external approximate multiplier over all
// nonzero operand pairs, accumulating count, ED sum, max ED and scaled RED sum.
module approx_mult_err_sweeper
   import approx_mult_pkg::*;
#(
   parameter int W            = 8,
   parameter int MULT_LATENCY = 0,
   parameter int SCALE        = 10000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic           abort_i,
   output logic [W-1:0]   mult_a_o,
   output logic [W-1:0]   mult_b_o,
   input  logic [2*W-1:0] mult_r_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [2*W-1:0] err_count_o,
   output logic [31:0]    ed_sum_o,
   output logic [2*W-1:0] max_ed_o,
   output logic [63:0]    red_sum_o
);
   localparam int PW = 2 * W;
   localparam int NW = div_cycles(W);
   localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
   localparam logic [W-1:0] OP_MAX = '1;
   localparam logic [W-1:0] OP_ONE = W'(1);

   sweep_state_e  state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, ma_q, ma_d, mb_q, mb_d;
   logic [CW-1:0] wait_q, wait_d;
   logic [PW-1:0] err_q, err_d, max_q, max_d;
   logic [31:0]   eds_q, eds_d;
   logic [63:0]   red_q, red_d;

   logic [PW-1:0] exact, ed;
   logic [32:0]   ed_sum_add;
   logic [31:0]   ed_sum_sat;
   logic [NW-1:0] dividend, div_quo;
   logic          div_start, div_flush, div_done, advance, last_pair;

   assign exact      = PW'(exact_product(32'(a_q), 32'(b_q)));
   assign ed         = (mult_r_i >= exact) ? mult_r_i - exact : exact - mult_r_i;
   assign ed_sum_add = {1'b0, eds_q} + 33'(ed);
   assign ed_sum_sat = ed_sum_add[32] ? '1 : ed_sum_add[31:0];
   assign dividend   = NW'(ed) * NW'(SCALE);
   assign last_pair  = (a_q == OP_MAX) && (b_q == OP_MAX);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      wait_d    = wait_q;
      err_d     = err_q;
      eds_d     = eds_q;
      max_d     = max_q;
      red_d     = red_q;
      div_start = 1'b0;
      div_flush = 1'b0;
      advance   = 1'b0;
      case (state_q)
         ST_IDLE: if (start_i) begin
            err_d   = '0;
            eds_d   = '0;
            max_d   = '0;
            red_d   = '0;
            a_d     = OP_ONE;
            b_d     = OP_ONE;
            state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            ma_d = a_q;
            mb_d = b_q;
            if (MULT_LATENCY > 0) begin
               wait_d  = CW'(MULT_LATENCY - 1);
               state_d = ST_WAIT;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_WAIT: if (wait_q == '0) state_d = ST_CHECK;
                  else wait_d = wait_q - CW'(1);
         ST_CHECK: if (ed != '0) begin
            err_d     = err_q + PW'(1);
            eds_d     = ed_sum_sat;
            max_d     = (ed > max_q) ? ed : max_q;
            div_start = 1'b1;
            state_d   = ST_DIV;
         end else begin
            advance = 1'b1;
         end
         ST_DIV: if (div_done) state_d = ST_ACC;
         ST_ACC: begin
            red_d   = red_q + 64'(div_quo);
            advance = 1'b1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (last_pair) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_DRIVE;
            if (b_q == OP_MAX) begin
               b_d = OP_ONE;
               a_d = a_q + OP_ONE;
            end else begin
               b_d = b_q + OP_ONE;
            end
         end
      end

      // Abort overrides everything above: partial results stay frozen.
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         err_d     = err_q;
         eds_d     = eds_q;
         max_d     = max_q;
         red_d     = red_q;
         div_start = 1'b0;
         div_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         wait_q  <= '0;
         err_q   <= '0;
         eds_q   <= '0;
         max_q   <= '0;
         red_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         eds_q   <= eds_d;
         max_q   <= max_d;
         red_q   <= red_d;
      end
   end

   seq_div_restoring #(
      .NW(NW),
      .DW(PW)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (div_start),
      .flush_i   (div_flush),
      .dividend_i(dividend),
      .divisor_i (exact),
      .done_o    (div_done),
      .quotient_o(div_quo)
   );

   assign mult_a_o    = ma_q;
   assign mult_b_o    = mb_q;
   assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done_o      = (state_q == ST_DONE);
   assign err_count_o = err_q;
   assign ed_sum_o    = eds_q;
   assign max_ed_o    = max_q;
   assign red_sum_o   = red_q;

endmodule

// File: tb/tb_approx_mult_err_sweeper.sv
// Scoreboard bench for approx_mult_err_sweeper: stub multipliers with known
// error patterns, reference sweep model, abort and mid-divide reset scenarios.
`timescale 1ns/1ps
module tb_approx_mult_err_sweeper;
   localparam int W     = 4;
   localparam int PW    = 2 * W;
   localparam int L_LAT = 3;
   localparam int SCALE = 10000;
   localparam int NW    = 2 * W + 14;
   localparam int OPM   = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          start = 1'b0, abort = 1'b0;
   logic [W-1:0]  ma, mb;
   logic [PW-1:0] mr, err, maxe;
   logic          busy, done;
   logic [31:0]   eds;
   logic [63:0]   red;

   logic          start_l = 1'b0, abort_l = 1'b0;
   logic [W-1:0]  ma_l, mb_l;
   logic [PW-1:0] mr_l, err_l, maxe_l;
   logic          busy_l, done_l;
   logic [31:0]   eds_l;
   logic [63:0]   red_l;
   logic [PW-1:0] p1 = '0, p2 = '0, p3 = '0;

   int mode = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      longint err;
      longint eds;
      longint maxe;
      longint red;
      longint cyc;
   } exp_t;
   exp_t sb_q[$];

   approx_mult_err_sweeper #(.W(W), .MULT_LATENCY(0), .SCALE(SCALE)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
      .mult_a_o(ma), .mult_b_o(mb), .mult_r_i(mr), .busy_o(busy), .done_o(done),
      .err_count_o(err), .ed_sum_o(eds), .max_ed_o(maxe), .red_sum_o(red)
   );

   approx_mult_err_sweeper #(.W(W), .MULT_LATENCY(L_LAT), .SCALE(SCALE)) u_dut_lat (
      .clk(clk), .rst_n(rst_n), .start_i(start_l), .abort_i(abort_l),
      .mult_a_o(ma_l), .mult_b_o(mb_l), .mult_r_i(mr_l), .busy_o(busy_l), .done_o(done_l),
      .err_count_o(err_l), .ed_sum_o(eds_l), .max_ed_o(maxe_l), .red_sum_o(red_l)
   );

   // Stub: 0 exact, 1 wrong at (1,1), 2 wrong at (max,max), 3 wrong when a+b is a multiple of 8.
   function automatic logic [PW-1:0] stub_val(int m, int a, int b);
      int ex;
      int r;
      ex = a * b;
      r  = ex;
      case (m)
         1: if (a == 1 && b == 1) r = 3;
         2: if (a == OPM && b == OPM) r = 0;
         3: if ((a + b) % 8 == 0) r = (a % 2 == 1) ? ex - 1 : ex + a;
         default: r = ex;
      endcase
      return PW'(r);
   endfunction

   assign mr = stub_val(mode, int'(ma), int'(mb));

   // Three-stage pipelined exact multiplier for the latency instance.
   always @(posedge clk) begin
      p1 <= PW'(ma_l) * PW'(mb_l);
      p2 <= p1;
      p3 <= p2;
   end
   assign mr_l = p3;

   // Reference sweep; stops before pair (stop_a, stop_b) when that pair is reached.
   function automatic exp_t model(int m, int lat, int stop_a, int stop_b);
      exp_t e;
      e = '{default: 0};
      for (int a = 1; a <= OPM; a++) begin
         for (int b = 1; b <= OPM; b++) begin
            int ex;
            int r;
            int ed;
            if (a == stop_a && b == stop_b) return e;
            ex = a * b;
            r  = int'(stub_val(m, a, b));
            ed = (r > ex) ? r - ex : ex - r;
            if (ed != 0) begin
               e.err++;
               e.eds += ed;
               if (ed > e.maxe) e.maxe = ed;
               e.red += (longint'(ed) * SCALE) / ex;
               e.cyc += 2 + lat + NW + 1;
            end else begin
               e.cyc += 2 + lat;
            end
         end
      end
      return e;
   endfunction

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
      end
   endtask

   task automatic run_sweep(string tag, int m, bit lat, bit poke, bit with_abort);
      exp_t e;
      int   cyc;
      bit   seen;
      mode = m;
      sb_q.push_back(model(m, lat ? L_LAT : 0, 0, 0));
      @(negedge clk);
      if (lat) start_l = 1'b1;
      else     start   = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0; start_l = 1'b0; abort = 1'b0;
      check_eq({tag, "_busy_rise"}, lat ? busy_l : busy, 1);
      cyc  = 0;
      seen = 0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         if (lat ? done_l : done) begin
            seen = 1;
         end else begin
            if (lat ? busy_l : busy) cyc++;
            if (poke) start = (i == 40);
            @(negedge clk);
         end
      end
      start = 1'b0;
      e = sb_q.pop_front();
      check_eq({tag, "_done_seen"}, 64'(seen), 1);
      check_eq({tag, "_err_count"}, lat ? 64'(err_l) : 64'(err), e.err);
      check_eq({tag, "_ed_sum"}, lat ? 64'(eds_l) : 64'(eds), e.eds);
      check_eq({tag, "_max_ed"}, lat ? 64'(maxe_l) : 64'(maxe), e.maxe);
      check_eq({tag, "_red_sum"}, lat ? red_l : red, e.red);
      check_eq({tag, "_busy_cycles"}, 64'(cyc), e.cyc);
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, lat ? done_l : done, 0);
      $display("sweep %s: err_count=%0d ed_sum=%0d max_ed=%0d red_sum=%0d busy_cycles=%0d",
               tag, lat ? err_l : err, lat ? eds_l : eds, lat ? maxe_l : maxe,
               lat ? red_l : red, cyc);
   endtask

   task automatic wait_pair(string tag, int a, int b);
      bit hit;
      hit = 0;
      for (int i = 0; i < 20000 && !hit; i++) begin
         if (int'(ma) == a && int'(mb) == b) hit = 1;
         else @(negedge clk);
      end
      check_eq({tag, "_pair_reached"}, 64'(hit), 1);
   endtask

   initial begin
      exp_t e;
      int   done_cnt;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_operands", {ma, mb}, 0);
      check_eq("reset_accums", 64'(err) | 64'(eds) | 64'(maxe) | red, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep("latency3_exact", 0, 1'b1, 1'b0, 1'b0);
      run_sweep("exact", 0, 1'b0, 1'b0, 1'b0);
      run_sweep("err_first_pair", 1, 1'b0, 1'b0, 1'b0);
      run_sweep("err_last_pair", 2, 1'b0, 1'b0, 1'b0);
      run_sweep("err_pattern_start_ignored", 3, 1'b0, 1'b1, 1'b0);

      // Abort while pair (10,5) is being checked.
      mode = 3;
      sb_q.push_back(model(3, 0, 10, 5));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_pair("abort", 10, 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_busy_fall", busy, 0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check_eq("abort_no_done", 64'(done_cnt), 0);
      e = sb_q.pop_front();
      check_eq("abort_err_count", 64'(err), e.err);
      check_eq("abort_ed_sum", 64'(eds), e.eds);
      check_eq("abort_max_ed", 64'(maxe), e.maxe);
      check_eq("abort_red_sum", red, e.red);
      $display("abort at (10,5): err_count=%0d ed_sum=%0d red_sum=%0d", err, eds, red);

      run_sweep("after_abort_start_wins", 3, 1'b0, 1'b0, 1'b1);

      // Reset asserted while the divider works on pair (1,7).
      mode = 3;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_pair("rst_div", 1, 7);
      repeat (5) @(negedge clk);
      check_eq("rst_div_pre_err", 64'(err), 1);
      check_eq("rst_div_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_div_busy", busy, 0);
      check_eq("rst_div_done", done, 0);
      check_eq("rst_div_operands", {ma, mb}, 0);
      check_eq("rst_div_accums", 64'(err) | 64'(eds) | 64'(maxe) | red, 0);
      $display("reset during divide: outputs cleared");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep("after_reset", 3, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
